taxi_axi_err_slv: RTL

AXI4 default (error) slave terminating a crossbar master port that maps to an unpopulated address region. It accepts and discards write bursts, answering each with a single error B response. It answers each read burst with ARLEN+1 error R beats. It sits directly downstream of `taxi_axi_crossbar_1s` on any `m_axi[n]` port, giving stray accesses a legal, deadlock-free AXI4 termination.

---
 rtl/taxi_axi_err_slv_if.sv | 102 ++++++++++
 rtl/taxi_axi_err_slv.sv | 129 ++++++++++++
 2 files changed

// File: rtl/taxi_axi_err_slv_if.sv
// taxi_axi_if: AXI4 bus bundle shared by crossbar ports and their slaves.
//   Parameters: DATA_W, ADDR_W, ID_W and the per-channel user widths.
//   Modports:
//     wr_slv / wr_mst : AW, W and B channels seen from slave / master side.
//     rd_slv / rd_mst : AR and R channels seen from slave / master side.
`timescale 1ns/1ps
interface taxi_axi_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ID_W     = 8,
  parameter int AWUSER_W = 1,
  parameter int WUSER_W  = 1,
  parameter int BUSER_W  = 1,
  parameter int ARUSER_W = 1,
  parameter int RUSER_W  = 1
);
  // AW channel
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic [3:0]          awregion;
  logic [AWUSER_W-1:0] awuser;
  logic                awvalid;
  logic                awready;
  // W channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic [WUSER_W-1:0]  wuser;
  logic                wvalid;
  logic                wready;
  // B channel
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic [BUSER_W-1:0]  buser;
  logic                bvalid;
  logic                bready;
  // AR channel
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;
  // R channel
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [RUSER_W-1:0]  ruser;
  logic                rvalid;
  logic                rready;

  modport wr_slv (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready
  );

  modport wr_mst (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready
  );

  modport rd_slv (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport rd_mst (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
endinterface

// File: rtl/taxi_axi_err_slv.sv
// taxi_axi_err_slv: AXI4 default slave for unpopulated address regions.
//   Writes are accepted and discarded, answered by one B beat carrying RESP.
//   Reads are answered with ARLEN+1 R beats of RDATA_FILL carrying RESP.
// Parameters:
//   RESP       : response code on BRESP/RRESP (2'b11 DECERR, 2'b10 SLVERR).
//   RDATA_FILL : constant read data (low DATA_W bits used).
// Ports:
//   clk      : clock, rising edge.
//   rst      : asynchronous active-low reset.
//   s_axi_wr : AW/W/B slave side.
//   s_axi_rd : AR/R slave side.
`timescale 1ns/1ps
module taxi_axi_err_slv #(
  parameter logic [1:0]    RESP       = 2'b11,
  parameter logic [1023:0] RDATA_FILL = '0
) (
  input  logic       clk,
  input  logic       rst,
  taxi_axi_if.wr_slv s_axi_wr,
  taxi_axi_if.rd_slv s_axi_rd
);

  localparam int RD_DATA_W = $bits(s_axi_rd.rdata);

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [0:0] {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic [7:0] rd_cnt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = s_axi_wr.awvalid && s_axi_wr.awready;
  assign w_hs  = s_axi_wr.wvalid  && s_axi_wr.wready;
  assign b_hs  = s_axi_wr.bvalid  && s_axi_wr.bready;
  assign ar_hs = s_axi_rd.arvalid && s_axi_rd.arready;
  assign r_hs  = s_axi_rd.rvalid  && s_axi_rd.rready;

  assign s_axi_wr.buser = '0;
  assign s_axi_rd.ruser = '0;
  assign s_axi_rd.rdata = RDATA_FILL[RD_DATA_W-1:0];

  // Request payload beyond ids and arlen is intentionally discarded.
  logic unused_ok;
  assign unused_ok = ^{s_axi_wr.awaddr, s_axi_wr.awlen, s_axi_wr.awsize,
                       s_axi_wr.awburst, s_axi_wr.awlock, s_axi_wr.awcache,
                       s_axi_wr.awprot, s_axi_wr.awqos, s_axi_wr.awregion,
                       s_axi_wr.awuser, s_axi_wr.wdata, s_axi_wr.wstrb,
                       s_axi_wr.wuser, s_axi_rd.araddr, s_axi_rd.arsize,
                       s_axi_rd.arburst, s_axi_rd.arlock, s_axi_rd.arcache,
                       s_axi_rd.arprot, s_axi_rd.arqos, s_axi_rd.arregion,
                       s_axi_rd.aruser};

  // Write FSM next state; burst end is taken from wlast alone.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (aw_hs) wr_next = WR_DATA;
      WR_DATA: if (w_hs && s_axi_wr.wlast) wr_next = WR_RESP;
      WR_RESP: if (b_hs) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so that no
  // input-to-output combinational path exists and all are low in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state         <= WR_IDLE;
      s_axi_wr.awready <= 1'b0;
      s_axi_wr.wready  <= 1'b0;
      s_axi_wr.bvalid  <= 1'b0;
      s_axi_wr.bid     <= '0;
      s_axi_wr.bresp   <= 2'b00;
    end else begin
      wr_state         <= wr_next;
      s_axi_wr.awready <= (wr_next == WR_IDLE);
      s_axi_wr.wready  <= (wr_next == WR_DATA);
      s_axi_wr.bvalid  <= (wr_next == WR_RESP);
      if (aw_hs) begin
        s_axi_wr.bid   <= s_axi_wr.awid;
        s_axi_wr.bresp <= RESP;
      end
    end
  end

  // Read FSM next state; the final beat is the one flagged by rlast.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (r_hs && s_axi_rd.rlast) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state         <= RD_IDLE;
      s_axi_rd.arready <= 1'b0;
      s_axi_rd.rvalid  <= 1'b0;
      s_axi_rd.rlast   <= 1'b0;
      s_axi_rd.rid     <= '0;
      s_axi_rd.rresp   <= 2'b00;
      rd_cnt           <= 8'd0;
    end else begin
      rd_state         <= rd_next;
      s_axi_rd.arready <= (rd_next == RD_IDLE);
      s_axi_rd.rvalid  <= (rd_next == RD_DATA);
      if (ar_hs) begin
        s_axi_rd.rid   <= s_axi_rd.arid;
        s_axi_rd.rresp <= RESP;
        rd_cnt         <= s_axi_rd.arlen;
        s_axi_rd.rlast <= (s_axi_rd.arlen == 8'd0);
      end else if (r_hs) begin
        // rd_cnt counts beats remaining after the current one; rlast is
        // precomputed so it is valid in the same cycle as the beat.
        if (rd_cnt != 8'd0) begin
          rd_cnt         <= rd_cnt - 8'd1;
          s_axi_rd.rlast <= (rd_cnt == 8'd1);
        end else begin
          s_axi_rd.rlast <= 1'b0;
        end
      end
    end
  end

endmodule
